// File: rtl/comparator_2bit_bist.sv
// Built-in self-test engine for the 2-bit comparator: applies all 16 input
// vectors, checks each response and reports pass/fail, error count and first failing vector.
module comparator_2bit_bist #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A1,
    output logic       A0,
    output logic       B1,
    output logic       B0,
    input  logic       A_greater_B,
    input  logic       A_equals_B,
    input  logic       A_less_B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_seen,
    output logic [3:0] first_fail_vec
);

    generate
        if ((DWELL < 2) || (DWELL > 255)) begin : g_dwell_illegal
            $fatal(1, "comparator_2bit_bist: DWELL must be in 2..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    // Golden response for vector v = {a[1:0], b[1:0]}, ordered {gt, eq, lt}.
    function automatic logic [2:0] expected_resp(input logic [3:0] v);
        logic [1:0] a;
        logic [1:0] b;
        a = v[3:2];
        b = v[1:0];
        return {(a > b), (a == b), (a < b)};
    endfunction

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [7:0] dwell_q, dwell_d;
    logic [3:0] stim_q, stim_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] err_q, err_d;
    logic       fail_q, fail_d;
    logic [3:0] first_q, first_d;

    logic [2:0] resp_s;
    logic       mismatch_s;
    logic       check_s;
    logic       start_run_s;

    assign resp_s      = {A_greater_B, A_equals_B, A_less_B};
    assign mismatch_s  = (resp_s != expected_resp(vec_q));
    assign check_s     = (state_q == ST_RUN) && (dwell_q == DWELL_LAST);
    assign start_run_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state, counter and result logic.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        dwell_d = dwell_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        first_d = first_q;
        stim_d  = stim_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_run_s) begin
                    state_d = ST_RUN;
                    vec_d   = 4'd0;
                    dwell_d = 8'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 5'd0;
                    fail_d  = 1'b0;
                    first_d = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (check_s) begin
                    if (mismatch_s) begin
                        err_d = err_q + 5'd1;
                        if (!fail_q) begin
                            fail_d  = 1'b1;
                            first_d = vec_q;
                        end else begin
                            fail_d  = fail_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    dwell_d = 8'd0;
                    if (vec_q == 4'd15) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 5'd0);
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = 4'd0;
                dwell_d = 8'd0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // Stimulus follows the vector counter except in IDLE, where it is parked at zero.
        if (state_d == ST_IDLE) begin
            stim_d = 4'd0;
        end else begin
            stim_d = vec_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            dwell_q <= 8'd0;
            stim_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 5'd0;
            fail_q  <= 1'b0;
            first_q <= 4'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            first_q <= first_d;
        end
    end

    assign {A1, A0, B1, B0} = stim_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign fail_seen        = fail_q;
    assign first_fail_vec   = first_q;

endmodule

// File: tb/tb_comparator_2bit_bist.sv
// Scoreboard bench for comparator_2bit_bist: a fault-injectable comparator model
// answers the stimulus, and per-run results are predicted from the comparison rules.
module tb_comparator_2bit_bist;

    localparam int DWELL   = 4;
    localparam int RUN_CYC = 16 * DWELL;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       A1, A0, B1, B0;
    logic       A_greater_B, A_equals_B, A_less_B;
    logic       busy, done, pass, fail_seen;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec;

    int         fault_mode;
    logic [2:0] fault_mask [16];

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        int err;
        bit fs;
        int first;
        bit pass;
    } exp_t;

    exp_t sb_q[$];

    comparator_2bit_bist #(.DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A1(A1), .A0(A0), .B1(B1), .B0(B0),
        .A_greater_B(A_greater_B), .A_equals_B(A_equals_B), .A_less_B(A_less_B),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_seen(fail_seen), .first_fail_vec(first_fail_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ideal(input int v);
        int a;
        int b;
        a = (v >> 2) & 3;
        b = v & 3;
        return {(a > b), (a == b), (a < b)};
    endfunction

    // Comparator under test, with selectable faults: 1 = eq stuck at 0, 2 = gt/lt swapped, 3 = random flips.
    function automatic logic [2:0] faulty(input int v, input logic [2:0] g);
        logic [2:0] r;
        case (fault_mode)
            1:       r = g & 3'b101;
            2:       r = {g[0], g[1], g[2]};
            3:       r = g ^ fault_mask[v];
            default: r = g;
        endcase
        return r;
    endfunction

    int vin;
    always_comb begin
        vin = int'({A1, A0, B1, B0});
        {A_greater_B, A_equals_B, A_less_B} = faulty(vin, ideal(vin));
    end

    function automatic exp_t model_run();
        exp_t e;
        e.err = 0; e.fs = 1'b0; e.first = 0;
        for (int v = 0; v < 16; v++) begin
            if (faulty(v, ideal(v)) != ideal(v)) begin
                e.err++;
                if (!e.fs) begin
                    e.fs    = 1'b1;
                    e.first = v;
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    function automatic int errors_before(input int n);
        int c = 0;
        for (int v = 0; v < n; v++)
            if (faulty(v, ideal(v)) != ideal(v)) c++;
        return c;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stim"}, int'({A1, A0, B1, B0}), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_fs"}, int'(fail_seen), 0);
        check({tag, "_first"}, int'(first_fail_vec), 0);
    endtask

    // Monitor: per-cycle stimulus sequence, run length, and end-of-run scoreboard pop.
    int   busy_cnt = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (busy) begin
                if (busy_cnt == 0) begin
                    check("clear_err", int'(err_count), 0);
                    check("clear_fs", int'(fail_seen), 0);
                    check("clear_done", int'(done), 0);
                end
                check("stim_vec", int'({A1, A0, B1, B0}), busy_cnt / DWELL);
                busy_cnt++;
            end
            if (done && !done_prev) begin
                check("busy_len", busy_cnt, RUN_CYC);
                busy_cnt = 0;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("err_count", int'(err_count), e.err);
                    check("fail_seen", int'(fail_seen), int'(e.fs));
                    check("pass", int'(pass), int'(e.pass));
                    check("busy_at_done", int'(busy), 0);
                    if (e.fs) check("first_fail_vec", int'(first_fail_vec), e.first);
                end
            end
            done_prev = done;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < RUN_CYC + 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", int'(seen), 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        fault_mode = 0;
        for (int i = 0; i < 16; i++) fault_mask[i] = 3'b000;

        // Reset behaviour.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_all_zero("reset");
        end

        // Healthy comparator, then stimulus held in DONE.
        fault_mode = 0;
        sb_q.push_back(model_run());
        pulse_start();
        wait_done();
        repeat (3) begin
            @(negedge clk);
            check("done_hold", int'(done), 1);
            check("stim_hold", int'({A1, A0, B1, B0}), 15);
        end

        // eq stuck at 0, then gt/lt swapped.
        for (int m = 1; m <= 2; m++) begin
            fault_mode = m;
            sb_q.push_back(model_run());
            pulse_start();
            wait_done();
        end

        // Random fault patterns with random idle gaps.
        for (int r = 0; r < 4; r++) begin
            fault_mode = 3;
            for (int i = 0; i < 16; i++)
                fault_mask[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            sb_q.push_back(model_run());
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulse_start();
            wait_done();
        end

        // start held high: run completes, then restarts from DONE with cleared results.
        fault_mode = 1;
        sb_q.push_back(model_run());
        @(negedge clk) start = 1'b1;
        wait_done();
        fault_mode = 0;
        sb_q.push_back(model_run());
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset mid-run while vector 7 is applied to a faulty comparator.
        fault_mode = 1;
        pulse_start();
        repeat (7 * DWELL) @(negedge clk);
        check("mid_vec", int'({A1, A0, B1, B0}), 7);
        check("mid_err", int'(err_count), errors_before(7));
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        fault_mode = 0;
        sb_q.push_back(model_run());
        pulse_start();
        wait_done();

        repeat (2) @(negedge clk);
        check("sb_leftover", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
